// File: rtl/drr_req_sched_if.sv
// Bundle of the drr_req_sched requester, snapshot, engine and response signals.
// The slave modport is the scheduler; the master modport is whatever drives it.
interface drr_req_sched_if #(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned CLASS_WIDTH         = 5,
    parameter int unsigned WEIGHT_WIDTH        = 16,
    parameter int unsigned PKT_WIDTH           = 16,
    parameter int unsigned RESULT_WIDTH        = 32,
    parameter int unsigned PIFO_OVERFLOW_WIDTH = 1,
    parameter int unsigned PIFO_ROUND_WIDTH    = 18
) ();
    // Requesters
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*CLASS_WIDTH-1:0]  req_class_id;
    logic [NUM_REQ*WEIGHT_WIDTH-1:0] req_class_weight;
    logic [NUM_REQ*PKT_WIDTH-1:0]    req_pkt_len;

    // Dequeued-PIFO snapshot input
    logic                            last_pifo_valid;
    logic [PIFO_OVERFLOW_WIDTH-1:0]  last_pifo_overflow;
    logic [PIFO_ROUND_WIDTH-1:0]     last_pifo_round;

    // Engine request
    logic                            eng_req_valid;
    logic [CLASS_WIDTH-1:0]          eng_req_class_id;
    logic [WEIGHT_WIDTH-1:0]         eng_req_class_weight;
    logic [WEIGHT_WIDTH-1:0]         eng_req_div_quotient;
    logic [WEIGHT_WIDTH-1:0]         eng_req_div_remain;
    logic                            eng_last_pifo_valid;
    logic [PIFO_OVERFLOW_WIDTH-1:0]  eng_last_pifo_overflow;
    logic [PIFO_ROUND_WIDTH-1:0]     eng_last_pifo_round;

    // Engine response and routed response
    logic                            eng_resp_valid;
    logic [RESULT_WIDTH-1:0]         eng_resp_data;
    logic [NUM_REQ-1:0]              resp_valid;
    logic [RESULT_WIDTH-1:0]         resp_data;

    // Status
    logic                            busy;
    logic                            err;

    modport master (
        output req_valid, req_class_id, req_class_weight, req_pkt_len,
        output last_pifo_valid, last_pifo_overflow, last_pifo_round,
        output eng_resp_valid, eng_resp_data,
        input  req_ready,
        input  eng_req_valid, eng_req_class_id, eng_req_class_weight,
        input  eng_req_div_quotient, eng_req_div_remain,
        input  eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round,
        input  resp_valid, resp_data, busy, err
    );

    modport slave (
        input  req_valid, req_class_id, req_class_weight, req_pkt_len,
        input  last_pifo_valid, last_pifo_overflow, last_pifo_round,
        input  eng_resp_valid, eng_resp_data,
        output req_ready,
        output eng_req_valid, eng_req_class_id, eng_req_class_weight,
        output eng_req_div_quotient, eng_req_div_remain,
        output eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round,
        output resp_valid, resp_data, busy, err
    );
endinterface

// File: rtl/drr_req_sched.sv
// DRR front-end scheduler: round-robin requester arbitration, iterative
// restoring divide of packet length by class weight, single outstanding engine
// request, response routing back to the owning requester, PIFO snapshot.
module drr_req_sched #(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned CLASS_WIDTH         = 5,
    parameter int unsigned WEIGHT_WIDTH        = 16,
    parameter int unsigned PKT_WIDTH           = 16,
    parameter int unsigned RESULT_WIDTH        = 32,
    parameter int unsigned PIFO_OVERFLOW_WIDTH = 1,
    parameter int unsigned PIFO_ROUND_WIDTH    = 18
) (
    input logic            clk,
    input logic            rst,
    drr_req_sched_if.slave io_if
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(PKT_WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDiv   = 2'd1,
        StIssue = 2'd2,
        StWait  = 2'd3
    } state_e;

    state_e                         r_state;
    state_e                         w_state_nxt;

    logic [IDX_W-1:0]               r_rr_ptr;
    logic [IDX_W-1:0]               r_owner;
    logic [IDX_W-1:0]               w_gnt_idx;
    logic                           w_gnt_any;
    logic [NUM_REQ-1:0]             w_grant;

    logic [CLASS_WIDTH-1:0]         w_sel_class;
    logic [WEIGHT_WIDTH-1:0]        w_sel_weight;
    logic [PKT_WIDTH-1:0]           w_sel_len;

    logic [CLASS_WIDTH-1:0]         r_class;
    logic [WEIGHT_WIDTH-1:0]        r_weight;
    logic                           r_wzero;
    // r_quo holds the dividend and accumulates quotient bits as they shift in
    logic [PKT_WIDTH-1:0]           r_quo;
    logic [WEIGHT_WIDTH-1:0]        r_rem;
    logic [CNT_W-1:0]               r_cnt;

    logic [WEIGHT_WIDTH:0]          w_rem_shift;
    logic [WEIGHT_WIDTH:0]          w_rem_sub;
    logic                           w_q_bit;

    logic                           w_accept;
    logic                           w_ready_en;
    logic                           w_eng_req_valid;

    logic                           r_snap_valid;
    logic [PIFO_OVERFLOW_WIDTH-1:0] r_snap_overflow;
    logic [PIFO_ROUND_WIDTH-1:0]    r_snap_round;

    logic [NUM_REQ-1:0]             r_resp_valid;
    logic [RESULT_WIDTH-1:0]        r_resp_data;
    logic                           r_err;

    // Round-robin grant: first valid requester after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_gnt_any && io_if.req_valid[idx[IDX_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = idx[IDX_W-1:0];
            end
        end
        w_grant = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    end

    assign w_sel_class  = io_if.req_class_id[w_gnt_idx*CLASS_WIDTH +: CLASS_WIDTH];
    assign w_sel_weight = io_if.req_class_weight[w_gnt_idx*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign w_sel_len    = io_if.req_pkt_len[w_gnt_idx*PKT_WIDTH +: PKT_WIDTH];

    // One restoring-division step: shift in next dividend bit, subtract if it fits.
    assign w_rem_shift = {r_rem, r_quo[PKT_WIDTH-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_weight};
    assign w_q_bit     = (w_rem_shift >= {1'b0, r_weight});

    // FSM next-state and control outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_ready_en      = 1'b0;
        w_eng_req_valid = 1'b0;
        w_accept        = 1'b0;
        case (r_state)
            StIdle: begin
                w_ready_en = ~rst;
                if (w_gnt_any && !rst) begin
                    w_accept    = 1'b1;
                    // Weight 0 has a fixed result, so the divider is skipped
                    w_state_nxt = (w_sel_weight == '0) ? StIssue : StDiv;
                end
            end
            StDiv: begin
                if (r_cnt == CNT_W'(PKT_WIDTH - 1)) begin
                    w_state_nxt = StIssue;
                end
            end
            StIssue: begin
                w_eng_req_valid = 1'b1;
                w_state_nxt     = StWait;
            end
            StWait: begin
                if (io_if.eng_resp_valid) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latch, owner/pointer update and divider iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= IDX_W'(NUM_REQ - 1);
            r_owner  <= '0;
            r_class  <= '0;
            r_weight <= '0;
            r_wzero  <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_gnt_idx;
            r_owner  <= w_gnt_idx;
            r_class  <= w_sel_class;
            r_weight <= w_sel_weight;
            r_wzero  <= (w_sel_weight == '0);
            r_quo    <= w_sel_len;
            r_rem    <= '0;
            r_cnt    <= '0;
        end else if (r_state == StDiv) begin
            r_quo <= (r_quo << 1) | PKT_WIDTH'(w_q_bit);
            r_rem <= w_q_bit ? w_rem_sub[WEIGHT_WIDTH-1:0] : w_rem_shift[WEIGHT_WIDTH-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // PIFO snapshot, loaded on any strobe regardless of state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snap_valid    <= 1'b0;
            r_snap_overflow <= '0;
            r_snap_round    <= '0;
        end else if (io_if.last_pifo_valid) begin
            r_snap_valid    <= 1'b1;
            r_snap_overflow <= io_if.last_pifo_overflow;
            r_snap_round    <= io_if.last_pifo_round;
        end
    end

    // Route engine responses to the owner; flag responses nobody is waiting for.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            if (io_if.eng_resp_valid) begin
                if (r_state == StWait) begin
                    r_resp_valid <= NUM_REQ'(1) << r_owner;
                    r_resp_data  <= io_if.eng_resp_data;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign io_if.req_ready              = w_ready_en ? w_grant : '0;
    assign io_if.eng_req_valid          = w_eng_req_valid;
    assign io_if.eng_req_class_id       = r_class;
    assign io_if.eng_req_class_weight   = r_weight;
    assign io_if.eng_req_div_quotient   = r_wzero ? '1 : WEIGHT_WIDTH'(r_quo);
    assign io_if.eng_req_div_remain     = r_rem;
    assign io_if.eng_last_pifo_valid    = r_snap_valid;
    assign io_if.eng_last_pifo_overflow = r_snap_overflow;
    assign io_if.eng_last_pifo_round    = r_snap_round;
    assign io_if.resp_valid             = r_resp_valid;
    assign io_if.resp_data              = r_resp_data;
    assign io_if.busy                   = (r_state != StIdle);
    assign io_if.err                    = r_err;

endmodule

// File: doc/drr_req_sched.md
# drr_req_sched

Front-end scheduler for `drr_engine_pipe`. It arbitrates round-robin among NUM_REQ enqueue requesters and computes the DRR quotient and remainder (packet length / class weight) with an iterative divider. It issues one request at a time to the engine and routes the engine response back to the requester that owns it. It also keeps the latest dequeued-PIFO snapshot (overflow, round) and presents it to the engine alongside each request.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CLASS_WIDTH, 5, class id width
- WEIGHT_WIDTH, 16, class weight / quotient / remainder width
- PKT_WIDTH, 16, packet length width; must be ≤ WEIGHT_WIDTH
- RESULT_WIDTH, 32, engine response width
- PIFO_OVERFLOW_WIDTH, 1, overflow tag width
- PIFO_ROUND_WIDTH, 18, round width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_class_id  in  NUM_REQ*CLASS_WIDTH  packed, requester i at slice i
- req_class_weight  in  NUM_REQ*WEIGHT_WIDTH  packed
- req_pkt_len  in  NUM_REQ*PKT_WIDTH  packed
- last_pifo_valid  in  1  snapshot update strobe
- last_pifo_overflow  in  PIFO_OVERFLOW_WIDTH
- last_pifo_round  in  PIFO_ROUND_WIDTH
- eng_req_valid  out  1  engine request (one-cycle pulse)
- eng_req_class_id, eng_req_class_weight, eng_req_div_quotient, eng_req_div_remain  out  CLASS_WIDTH / WEIGHT_WIDTH ×3
- eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round  out  1 / PIFO_OVERFLOW_WIDTH / PIFO_ROUND_WIDTH
- eng_resp_valid  in  1;  eng_resp_data  in  RESULT_WIDTH
- resp_valid  out  NUM_REQ  one-hot response strobe;  resp_data  out  RESULT_WIDTH
- busy  out  1  state ≠ IDLE;  err  out  1  sticky spurious-response flag

## Operation
- FSM states: IDLE, DIV, ISSUE, WAIT.
- IDLE:
  - The round-robin grant searches from rr_ptr+1 upward, wrapping at NUM_REQ.
  - req_ready[g] = (state==IDLE) && grant[g], combinational.
  - On valid&ready: latch class, weight, len and owner=g, set rr_ptr=g, then go to DIV. If weight==0, go to ISSUE instead.
- DIV: restoring divider, one quotient bit per cycle, exactly PKT_WIDTH cycles. Quotient is zero-extended to WEIGHT_WIDTH. Then go to ISSUE.
- Weight 0: quotient = all ones, remain = 0, no divide.
- ISSUE: eng_req_valid=1 for exactly one cycle with the latched operands, then go to WAIT.
- WAIT:
  - On eng_resp_valid: resp_valid[owner]=1 and resp_data=eng_resp_data on the next cycle (registered), and the state returns to IDLE in that same next cycle.
  - There is no timeout; the engine returns a response 3 cycles after ISSUE.
- Snapshot registers:
  - Loaded whenever last_pifo_valid=1, in any state. snap_valid is set by the first load.
  - eng_last_pifo_* are driven directly from these registers.
- eng_resp_valid in any state other than WAIT is dropped and sets err=1 until reset.
- Reset values:
  - state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 has first priority).
  - All outputs 0: req_ready, eng_req_*, eng_last_pifo_*, resp_valid, resp_data, busy, err.
  - Snapshot registers 0.
- Reset during DIV/ISSUE/WAIT aborts the transaction: no resp_valid is produced, and the engine response arriving after reset release sets err.

## Timing
- Handshake accepted at cycle T.
- DIV occupies T+1..T+PKT_WIDTH; eng_req_valid is high at T+PKT_WIDTH+1.
- The engine response arrives at T+PKT_WIDTH+4; resp_valid is high at T+PKT_WIDTH+5. Accept-to-response latency is PKT_WIDTH+5.
- Weight-0 path: eng_req_valid at T+1, resp_valid at T+5.
- Next accept is possible in the resp_valid cycle. Throughput is one request per PKT_WIDTH+5 cycles.
- Requests to the engine therefore never overlap, so there is no read-after-write hazard on per-class state.
- A snapshot update in the ISSUE cycle is not seen by that request; it is seen by the next one.
- req_* inputs need only be stable in the handshake cycle.

## Test plan
- Req0: class 3, weight 100, len 1500 -> eng_req_valid at T+17 with quotient 15, remain 0. Engine returns 0x8001_2000 -> resp_valid=4'b0001 at T+21 with resp_data 0x8001_2000.
- Req2: weight 64, len 1500 -> quotient 23, remain 28; only resp_valid[2] pulses.
- All four req_valid held high from reset -> grant order 0,1,2,3,0. Each accept is 21 cycles after the previous one, and req_ready is never multi-hot.
- Weight 0, len 500 -> quotient 0xFFFF, remain 0, eng_req_valid at T+1.
- last_pifo_valid with overflow 1, round 0x00123 before accept -> eng_last_pifo_valid=1, overflow 1, round 0x00123 during ISSUE. An update in the ISSUE cycle itself is not reflected there.
- Assert rst at T+8 mid-DIV -> after release, state is IDLE with all outputs 0. Pulse eng_resp_valid -> err=1 and no resp_valid.
